// File: rtl/pcs_transmit.sv
// pcs_transmit: 1000BASE-X PCS transmit path (GMII octets -> 10-bit code groups with 8b/10b and RD tracking).
// Optional macro PCS_TX_FRAME_COUNT_EN adds the frame_count output (number of /S/ emitted).
module pcs_transmit #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               Clk,
    input  logic               mr_main_reset,
    input  logic [7:0]         TXD,
    input  logic               TX_EN,
    input  logic               TX_ER,
    output logic [9:0]         tx_code_group,
    output logic               tx_even,
`ifdef PCS_TX_FRAME_COUNT_EN
    output logic               transmitting,
    output logic [COUNT_W-1:0] frame_count
`else
    output logic               transmitting
`endif
);

    localparam logic [2:0] IDLE_K = 3'd0;
    localparam logic [2:0] IDLE_D = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] EPD_R1 = 3'd3;
    localparam logic [2:0] EPD_R2 = 3'd4;

    // Special code groups, RD- form; the RD+ form is the bitwise complement.
    localparam logic [9:0] K28_5 = 10'b0011111010;
    localparam logic [9:0] K27_7 = 10'b1101101000;
    localparam logic [9:0] K29_7 = 10'b1011101000;
    localparam logic [9:0] K23_7 = 10'b1110101000;
    localparam logic [9:0] K30_7 = 10'b0111101000;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;

    logic [2:0]  state_q, state_d;
    logic [9:0]  code_q, code_d;
    logic        rd_q, rd_d;
    logic        even_q, even_d;
    logic        xmit_q, xmit_d;
    logic [7:0]  enc_in;
    logic [10:0] enc;

    function automatic logic [9:0] kcode(input logic [9:0] neg, input logic rd);
        return rd ? ~neg : neg;
    endfunction

    // Returns {rd_after, abcdei, fghj}; rd = 1 means positive running disparity.
    function automatic logic [10:0] enc_data(input logic [7:0] d, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd_mid;
        logic       rd_out;
        x = d[4:0];
        y = d[7:5];
        case (x)
            5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;
            5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
            5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
            5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
            5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;
            5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
            5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;
            5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
            5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
            5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
            5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;
            5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
            5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;
            5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
            5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;
            5'd30: c6 = 6'b011110;  default: c6 = 6'b101011;
        endcase
        // Unbalanced groups flip for RD+; D.7 is balanced but still alternates.
        if (rd && (($countones(c6) != 3) || (x == 5'd7)))
            c6 = ~c6;
        rd_mid = ($countones(c6) == 3) ? rd : ~rd;
        case (y)
            3'd0: c4 = 4'b1011;
            3'd1: c4 = 4'b1001;
            3'd2: c4 = 4'b0101;
            3'd3: c4 = 4'b1100;
            3'd4: c4 = 4'b1101;
            3'd5: c4 = 4'b1010;
            3'd6: c4 = 4'b0110;
            default: begin
                if ((!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                    ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)))
                    c4 = 4'b0111;
                else
                    c4 = 4'b1110;
            end
        endcase
        if (rd_mid && (($countones(c4) != 2) || (y == 3'd3)))
            c4 = ~c4;
        rd_out = ($countones(c4) == 2) ? rd_mid : ~rd_mid;
        return {rd_out, c6, c4};
    endfunction

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rd_d    = rd_q;
        xmit_d  = xmit_q;
        even_d  = ~even_q;
        // In IDLE_D, rd_q is the RD after K28.5: positive means RD was negative before it -> /I2/.
        enc_in  = (state_q == IDLE_D) ? (rd_q ? D16_2 : D5_6) : TXD;
        enc     = enc_data(enc_in, rd_q);
        case (state_q)
            IDLE_K: begin
                if (TX_EN) begin
                    code_d  = kcode(K27_7, rd_q);
                    xmit_d  = 1'b1;
                    state_d = DATA;
                end else begin
                    code_d  = kcode(K28_5, rd_q);
                    rd_d    = ~rd_q;
                    xmit_d  = 1'b0;
                    state_d = IDLE_D;
                end
            end
            IDLE_D: begin
                code_d  = enc[9:0];
                rd_d    = enc[10];
                xmit_d  = 1'b0;
                state_d = IDLE_K;
            end
            DATA: begin
                xmit_d = 1'b1;
                if (!TX_EN) begin
                    code_d  = kcode(K29_7, rd_q);
                    state_d = EPD_R1;
                end else if (TX_ER) begin
                    code_d = kcode(K30_7, rd_q);
                end else begin
                    code_d = enc[9:0];
                    rd_d   = enc[10];
                end
            end
            EPD_R1: begin
                code_d  = kcode(K23_7, rd_q);
                xmit_d  = 1'b0;
                state_d = even_d ? EPD_R2 : IDLE_K;
            end
            EPD_R2: begin
                code_d  = kcode(K23_7, rd_q);
                xmit_d  = 1'b0;
                state_d = IDLE_K;
            end
            default: state_d = IDLE_K;
        endcase
    end

    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state_q <= IDLE_K;
            code_q  <= '0;
            rd_q    <= 1'b0;
            even_q  <= 1'b0;
            xmit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            rd_q    <= rd_d;
            even_q  <= even_d;
            xmit_q  <= xmit_d;
        end
    end

    assign tx_code_group = code_q;
    assign tx_even       = even_q;
    assign transmitting  = xmit_q;

`ifdef PCS_TX_FRAME_COUNT_EN
    logic [COUNT_W-1:0] fcnt_q;

    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset)
            fcnt_q <= '0;
        else if (state_q == IDLE_K && TX_EN)
            fcnt_q <= fcnt_q + 1'b1;
    end

    assign frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_pcs_transmit.sv
// Self-checking bench for pcs_transmit: directed literal-code scenarios plus randomized frames
// checked against a slot-level reference model using integer running disparity.
`timescale 1ns/1ps
module tb_pcs_transmit;

    logic       Clk = 1'b0;
    logic       mr_main_reset = 1'b1;
    logic [7:0] TXD = 8'h00;
    logic       TX_EN = 1'b0;
    logic       TX_ER = 1'b0;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       transmitting;
`ifdef PCS_TX_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pcs_transmit #(.COUNT_W(16)) dut (
        .Clk           (Clk),
        .mr_main_reset (mr_main_reset),
        .TXD           (TXD),
        .TX_EN         (TX_EN),
        .TX_ER         (TX_ER),
        .tx_code_group (tx_code_group),
        .tx_even       (tx_even),
`ifdef PCS_TX_FRAME_COUNT_EN
        .transmitting  (transmitting),
        .frame_count   (frame_count)
`else
        .transmitting  (transmitting)
`endif
    );

    // Reference model: 5b/6b and 3b/4b in RD- form, RD held as -1/+1.
    logic [5:0] T6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                            6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                            6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                            6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                            6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                            6'b011110, 6'b101011};
    logic [3:0] T4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

    localparam logic [9:0] K285N = 10'b0011111010, K285P = 10'b1100000101;
    localparam logic [9:0] SN = 10'b1101101000, SP = 10'b0010010111;
    localparam logic [9:0] TN = 10'b1011101000, TP = 10'b0100010111;
    localparam logic [9:0] RN = 10'b1110101000, RP = 10'b0001010111;
    localparam logic [9:0] VN = 10'b0111101000, VP = 10'b1000010111;

    int          m_slot, m_rd, m_k_rd, m_r_left;
    bit          m_in_frame;
    logic [15:0] m_frames;
    logic [9:0]  exp_code;
    logic        exp_even, exp_tx;

    function automatic int disp(input logic [5:0] v, input int n);
        int o = 0;
        for (int i = 0; i < n; i++) o += int'(v[i]);
        return 2 * o - n;
    endfunction

    task automatic model_reset();
        m_slot = 0; m_rd = -1; m_k_rd = -1; m_r_left = 0; m_in_frame = 0; m_frames = '0;
    endtask

    task automatic enc_model(input logic [7:0] d, output logic [9:0] code);
        logic [5:0] c6;
        logic [3:0] c4;
        int x, y;
        x = int'(d[4:0]);
        y = int'(d[7:5]);
        c6 = T6[x];
        if (m_rd + disp(c6, 6) > 1 || (m_rd > 0 && x == 7)) c6 = ~c6;
        m_rd += disp(c6, 6);
        if (y == 7 && ((m_rd < 0 && (x == 17 || x == 18 || x == 20)) ||
                       (m_rd > 0 && (x == 11 || x == 13 || x == 14))))
            c4 = 4'b0111;
        else
            c4 = T4[y];
        if (m_rd + disp({2'b00, c4}, 4) > 1 || (m_rd > 0 && y == 3)) c4 = ~c4;
        m_rd += disp({2'b00, c4}, 4);
        code = {c6, c4};
    endtask

    task automatic model_step(input logic en, input logic er, input logic [7:0] d);
        bit even;
        even = (m_slot % 2 == 0);
        exp_even = even;
        if (m_r_left > 0) begin
            exp_code = (m_rd < 0) ? RN : RP; exp_tx = 0; m_r_left--;
        end else if (m_in_frame) begin
            exp_tx = 1;
            if (!en) begin
                exp_code = (m_rd < 0) ? TN : TP;
                m_in_frame = 0;
                m_r_left = even ? 1 : 2;   // pad /R/ so the next idle starts on an even slot
            end else if (er) exp_code = (m_rd < 0) ? VN : VP;
            else enc_model(d, exp_code);
        end else if (even) begin
            if (en) begin
                exp_code = (m_rd < 0) ? SN : SP; exp_tx = 1; m_in_frame = 1; m_frames++;
            end else begin
                exp_code = (m_rd < 0) ? K285N : K285P; exp_tx = 0;
                m_k_rd = m_rd; m_rd = -m_rd;
            end
        end else begin
            exp_tx = 0;
            enc_model((m_k_rd < 0) ? 8'h50 : 8'hC5, exp_code);
        end
        m_slot++;
    endtask

    task automatic drive_cycle(input logic en, input logic er, input logic [7:0] d);
        TX_EN = en; TX_ER = er; TXD = d;
        @(posedge Clk);
        model_step(en, er, d);
        #1;
    endtask

    task automatic align_even();
        while (m_slot % 2 != 0) drive_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        TX_EN = 0; TX_ER = 0; TXD = 0; mr_main_reset = 1;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({tx_code_group, tx_even, transmitting} !== 12'b0) begin
            errors++;
            $display("FAIL reset_values: code=%b even=%b xmit=%b, expected all zero", tx_code_group, tx_even, transmitting);
        end
        mr_main_reset = 0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            logic [9:0] want;
            want = (i % 2 == 0) ? 10'b0011111010 : 10'b1001000101;
            drive_cycle(1'b0, 1'b0, 8'h00);
            checks++;
            if (tx_code_group !== want || tx_even !== (i % 2 == 0) || transmitting !== 1'b0) begin
                errors++;
                $display("FAIL idle[%0d]: code=%b even=%b xmit=%b, expected code=%b even=%0d xmit=0", i, tx_code_group, tx_even, transmitting, want, (i % 2 == 0));
            end
        end
    endtask

    // 7x 0x55 + 0xD5: /S/ replaces the first octet, /T/ lands even, one /R/.
    task automatic test_preamble();
        logic [9:0] want;
        align_even();
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive_cycle(1'b1, 1'b0, (i == 7) ? 8'hD5 : 8'h55);
            else drive_cycle(1'b0, 1'b0, 8'h00);
            if (i == 0) want = 10'b1101101000;
            else if (i < 7) want = 10'b1010100101;
            else if (i == 7) want = 10'b1010100110;
            else if (i == 8) want = 10'b1011101000;
            else if (i == 9) want = 10'b1110101000;
            else want = 10'b0011111010;
            checks++;
            if (tx_code_group !== want || tx_even !== (i % 2 == 0) || transmitting !== (i <= 8)) begin
                errors++;
                $display("FAIL preamble[%0d]: code=%b even=%b xmit=%b, expected code=%b even=%0d xmit=%0d", i, tx_code_group, tx_even, transmitting, want, (i % 2 == 0), (i <= 8));
            end
        end
    endtask

    // /S/ + 8 octets: /T/ lands odd, two /R/, then K28.5 on even.
    task automatic test_epd_odd();
        logic [9:0] want;
        align_even();
        for (int i = 0; i < 14; i++) begin
            if (i < 9) drive_cycle(1'b1, 1'b0, 8'h55);
            else drive_cycle(1'b0, 1'b0, 8'h00);
            if (i == 0) want = 10'b1101101000;
            else if (i < 9) want = 10'b1010100101;
            else if (i == 9) want = 10'b1011101000;
            else if (i < 12) want = 10'b1110101000;
            else if (i == 12) want = 10'b0011111010;
            else want = 10'b1001000101;
            checks++;
            if (tx_code_group !== want || tx_even !== (i % 2 == 0) || transmitting !== (i <= 9)) begin
                errors++;
                $display("FAIL epd_odd[%0d]: code=%b even=%b xmit=%b, expected code=%b even=%0d xmit=%0d", i, tx_code_group, tx_even, transmitting, want, (i % 2 == 0), (i <= 9));
            end
        end
    endtask

    // D3.0 from RD- ends RD+, so idle must insert /I1/ before returning to /I2/.
    task automatic test_rd_plus_end();
        logic [9:0] want [8] = '{10'b1101101000, 10'b1100011011, 10'b0100010111, 10'b0001010111,
                                 10'b1100000101, 10'b1010010110, 10'b0011111010, 10'b1001000101};
        align_even();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(i < 2, 1'b0, 8'h03);
            checks++;
            if (tx_code_group !== want[i] || tx_even !== (i % 2 == 0) || transmitting !== (i <= 2)) begin
                errors++;
                $display("FAIL rd_plus_end[%0d]: code=%b even=%b xmit=%b, expected code=%b even=%0d xmit=%0d", i, tx_code_group, tx_even, transmitting, want[i], (i % 2 == 0), (i <= 2));
            end
        end
    endtask

    task automatic test_tx_er();
        align_even();
        for (int i = 0; i < 13; i++) begin
            if (i < 9) drive_cycle(1'b1, (i == 4), (i == 4) ? 8'h00 : 8'($urandom));
            else drive_cycle(1'b0, 1'b0, 8'h00);
            checks++;
            if (tx_code_group !== exp_code || tx_even !== exp_even || transmitting !== exp_tx) begin
                errors++;
                $display("FAIL tx_er[%0d]: code=%b even=%b xmit=%b, expected code=%b even=%b xmit=%b", i, tx_code_group, tx_even, transmitting, exp_code, exp_even, exp_tx);
            end
        end
    endtask

    task automatic test_odd_start();
        align_even();
        drive_cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(i < 5, 1'b0, 8'h55);
            checks++;
            if (tx_code_group !== exp_code || tx_even !== exp_even || transmitting !== exp_tx ||
                (i == 1 && tx_code_group !== 10'b1101101000)) begin
                errors++;
                $display("FAIL odd_start[%0d]: code=%b even=%b xmit=%b, expected code=%b even=%b xmit=%b", i, tx_code_group, tx_even, transmitting, exp_code, exp_even, exp_tx);
            end
`ifdef PCS_TX_FRAME_COUNT_EN
            checks++;
            if (frame_count !== m_frames) begin
                errors++;
                $display("FAIL odd_start_count[%0d]: frame_count=%0d expected %0d", i, frame_count, m_frames);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 40; f++) begin
            int len, gap;
            len = $urandom_range(1, 16);
            gap = $urandom_range(1, 4);
            for (int c = 0; c < len + gap; c++) begin
                if (c < len) drive_cycle(1'b1, ($urandom_range(0, 15) == 0), 8'($urandom));
                else drive_cycle(1'b0, 1'($urandom), 8'($urandom));
                checks++;
                if (tx_code_group !== exp_code || tx_even !== exp_even || transmitting !== exp_tx) begin
                    errors++;
                    $display("FAIL random[f%0d c%0d]: code=%b even=%b xmit=%b, expected code=%b even=%b xmit=%b", f, c, tx_code_group, tx_even, transmitting, exp_code, exp_even, exp_tx);
                end
`ifdef PCS_TX_FRAME_COUNT_EN
                checks++;
                if (frame_count !== m_frames) begin
                    errors++;
                    $display("FAIL random_count[f%0d c%0d]: frame_count=%0d expected %0d", f, c, frame_count, m_frames);
                end
`endif
            end
        end
    endtask

    task automatic test_async_reset();
        align_even();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 8'($urandom));
        #3 mr_main_reset = 1;
        #1;
        checks++;
        if ({tx_code_group, tx_even, transmitting} !== 12'b0) begin
            errors++;
            $display("FAIL async_reset: code=%b even=%b xmit=%b, expected all zero", tx_code_group, tx_even, transmitting);
        end
`ifdef PCS_TX_FRAME_COUNT_EN
        checks++;
        if (frame_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_count: frame_count=%0d expected 0", frame_count);
        end
`endif
        repeat (2) @(posedge Clk);
        #1 mr_main_reset = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00);
            checks++;
            if (tx_code_group !== exp_code || tx_even !== exp_even || transmitting !== exp_tx ||
                (i == 0 && (tx_code_group !== 10'b0011111010 || tx_even !== 1'b1))) begin
                errors++;
                $display("FAIL restart[%0d]: code=%b even=%b xmit=%b, expected code=%b even=%b xmit=%b", i, tx_code_group, tx_even, transmitting, exp_code, exp_even, exp_tx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preamble();
        test_epd_odd();
        test_rd_plus_end();
        test_tx_er();
        test_odd_start();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
